// File: rtl/imem_pkg.sv
// Shared definitions for the instruction memory and its boot-time loader.
package imem_pkg;

  // Loader frame-parsing states.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN0  = 3'd1,
    LEN1  = 3'd2,
    DATA  = 3'd3,
    FLUSH = 3'd4,
    ERR   = 3'd5
  } loader_state_e;

  localparam int          IMEM_DEPTH = 256;
  localparam logic [7:0]  IMEM_SYNC  = 8'hA5;
  localparam logic [31:0] NOP_WORD   = 32'h00000013;

endpackage

// File: rtl/imem_word_packer.sv
// Collects four bytes into one little-endian 32-bit word.
// word_o is valid combinationally in the cycle word_ready_o is high,
// so the caller can register it on the edge that accepts byte 4.
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // Newest byte enters at the top, so after three bytes the first one sits in [7:0].
  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clear_i) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_data_i, shift_q[23:8]};
    end
  end

  // Byte counter and partial-word register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

  assign word_ready_o = byte_valid_i && !clear_i && (cnt_q == 2'd3);
  assign word_o       = {byte_data_i, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream and writes the words
// into instruction memory at byte addresses 0, 4, 8, ... while holding the core.
module imem_loader
  import imem_pkg::*;
#(
  parameter int         DEPTH     = IMEM_DEPTH,
  parameter logic [7:0] SYNC_BYTE = IMEM_SYNC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  // One extra index bit so a full-depth image never wraps the counter.
  localparam int          IDX_W   = $clog2(DEPTH) + 1;
  localparam logic [15:0] DEPTH_L = 16'(DEPTH);

  loader_state_e state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             we_q, we_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic        accept;
  logic        pack_clear;
  logic        pack_valid;
  logic        word_ready;
  logic [31:0] word;
  logic [15:0] new_len;

  assign rx_ready   = (state_q != FLUSH);
  assign accept     = rx_valid && rx_ready;
  assign pack_valid = accept && (state_q == DATA);
  assign new_len    = {rx_data, len_q[7:0]};

  imem_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (pack_clear),
    .byte_valid_i (pack_valid),
    .byte_data_i  (rx_data),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  // Frame parser: next state, length check, word index and write outputs.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    hold_d     = hold_q;
    done_d     = 1'b0;
    error_d    = error_q;
    pack_clear = 1'b0;
    case (state_q)
      IDLE, ERR: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d = LEN0;
          hold_d  = 1'b1;
          error_d = 1'b0;
        end
      end
      LEN0: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          len_d = new_len;
          if (new_len == 16'd0 || new_len > DEPTH_L) begin
            state_d = ERR;
            error_d = 1'b1;
            hold_d  = 1'b0;
          end else begin
            idx_d      = '0;
            pack_clear = 1'b1;
            state_d    = DATA;
          end
        end
      end
      DATA: begin
        if (word_ready) begin
          we_d    = 1'b1;
          waddr_d = {{(30-IDX_W){1'b0}}, idx_q, 2'b00};
          wdata_d = word;
          idx_d   = idx_q + 1'b1;
          if (16'(idx_q) == len_q - 16'd1) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        hold_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign we       = we_q;
  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign cpu_hold = hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule
